mvu_job_sched: RTL and testbench

- Per-MVU job scheduler for the NMVU-wide MVU array.
- Accepts job descriptors (packed config words) on one shared submission port and queues them per target MVU.
- Launches each job with a one-cycle start pulse, holding the descriptor stable, then waits for done.
- Aggregates completions and watchdog timeouts into maskable, sticky per-MVU interrupts; the testbench and system layer drive MVU starts through it.

---
 rtl/mvu_job_sched.sv | 173 +++++++++++++++++
 tb/tb_mvu_job_sched.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_job_sched.sv
// Per-MVU job scheduler: one descriptor FIFO and launch FSM per MVU channel,
// with a per-channel watchdog and sticky, maskable completion interrupts.
module mvu_job_sched #(
  parameter  int NMVU   = 8,
  parameter  int DESCW  = 64,
  parameter  int QDEPTH = 4,
  parameter  int TOW    = 16,
  localparam int MW     = (NMVU > 1) ? $clog2(NMVU) : 1,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sub_valid,
  output logic                  sub_ready,
  input  logic [MW-1:0]         sub_mvu,
  input  logic [DESCW-1:0]      sub_desc,
  output logic [NMVU-1:0]       start,
  output logic [NMVU*DESCW-1:0] desc,
  input  logic [NMVU-1:0]       done,
  output logic [NMVU-1:0]       busy,
  output logic [NMVU*CW-1:0]    qcount,
  input  logic [TOW-1:0]        timeout_cyc,
  input  logic [NMVU-1:0]       abort,
  input  logic [NMVU-1:0]       irq_mask,
  input  logic [NMVU-1:0]       irq_clr,
  output logic [NMVU-1:0]       irq,
  output logic [NMVU-1:0]       err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t           state_q  [NMVU];
  state_t           state_d  [NMVU];
  logic [DESCW-1:0] mem_q    [NMVU][QDEPTH];
  logic [PW-1:0]    wptr_q   [NMVU];
  logic [PW-1:0]    rptr_q   [NMVU];
  logic [CW-1:0]    count_q  [NMVU];
  logic [DESCW-1:0] desc_q   [NMVU];
  logic [TOW-1:0]   wd_q     [NMVU];
  logic [NMVU-1:0]  pend_q;
  logic [NMVU-1:0]  err_q;
  logic [NMVU-1:0]  sel;
  logic [NMVU-1:0]  push;
  logic [NMVU-1:0]  pop;
  logic [NMVU-1:0]  to_hit;
  logic [NMVU-1:0]  set_pend;
  logic [TOW-1:0]   wd_limit;

  assign wd_limit = timeout_cyc - TOW'(1);

  // Pop and watchdog expiry; abort suppresses both, done has priority over expiry.
  always_comb begin
    for (int i = 0; i < NMVU; i++) begin
      pop[i]    = (state_q[i] == S_IDLE) && (count_q[i] != '0) && !abort[i];
      to_hit[i] = (state_q[i] == S_RUN) && !abort[i] && !done[i] &&
                  (timeout_cyc != '0) && (wd_q[i] == wd_limit);
    end
  end

  // A full queue can still accept when its head is popped in the same cycle.
  always_comb begin
    sub_ready = 1'b0;
    for (int i = 0; i < NMVU; i++) begin
      sel[i] = (sub_mvu == MW'(i));
      if (sel[i]) begin
        sub_ready = (count_q[i] != CW'(QDEPTH)) || pop[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NMVU; i++) begin
      push[i] = sub_valid && sub_ready && sel[i] && !abort[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMVU; i++) begin
        state_q[i] <= S_IDLE;
      end
    end else begin
      for (int i = 0; i < NMVU; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NMVU; i++) begin
      state_d[i] = state_q[i];
      if (abort[i]) begin
        state_d[i] = S_IDLE;
      end else begin
        case (state_q[i])
          S_IDLE:  if (count_q[i] != '0) state_d[i] = S_START;
          S_START: state_d[i] = S_RUN;
          S_RUN:   if (done[i] || to_hit[i]) state_d[i] = S_IDLE;
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    start    = '0;
    busy     = '0;
    set_pend = '0;
    desc     = '0;
    qcount   = '0;
    for (int i = 0; i < NMVU; i++) begin
      start[i]               = (state_q[i] == S_START);
      busy[i]                = (state_q[i] != S_IDLE);
      set_pend[i]            = (state_q[i] == S_RUN) && !abort[i] && (done[i] || to_hit[i]);
      desc[i*DESCW +: DESCW] = desc_q[i];
      qcount[i*CW +: CW]     = count_q[i];
    end
  end

  assign irq = pend_q & ~irq_mask;
  assign err = err_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NMVU; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= sub_desc;
      end
    end
  end

  // Queue bookkeeping, launched descriptor, watchdog and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMVU; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
        desc_q[i]  <= '0;
        wd_q[i]    <= '0;
      end
      pend_q <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < NMVU; i++) begin
        if (abort[i]) begin
          wptr_q[i]  <= '0;
          rptr_q[i]  <= '0;
          count_q[i] <= '0;
        end else begin
          if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
          if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
          if (push[i] && !pop[i]) begin
            count_q[i] <= count_q[i] + CW'(1);
          end else if (pop[i] && !push[i]) begin
            count_q[i] <= count_q[i] - CW'(1);
          end
        end
        if (pop[i]) begin
          desc_q[i] <= mem_q[i][rptr_q[i]];
        end
        if (state_q[i] == S_START) begin
          wd_q[i] <= '0;
        end else if ((state_q[i] == S_RUN) && (wd_q[i] != '1)) begin
          wd_q[i] <= wd_q[i] + TOW'(1);
        end
        pend_q[i] <= set_pend[i] | (pend_q[i] & ~irq_clr[i]);
        err_q[i]  <= to_hit[i] | (err_q[i] & ~irq_clr[i]);
      end
    end
  end

endmodule

// File: tb/tb_mvu_job_sched.sv
// Bench for mvu_job_sched: directed scenarios plus a randomized run checked
// against a queue-based reference model of the scheduling rules.
module tb_mvu_job_sched;

  localparam int NMVU   = 8;
  localparam int DESCW  = 64;
  localparam int QDEPTH = 4;
  localparam int TOW    = 16;
  localparam int MW     = 3;
  localparam int CW     = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  sub_valid;
  logic                  sub_ready;
  logic [MW-1:0]         sub_mvu;
  logic [DESCW-1:0]      sub_desc;
  logic [NMVU-1:0]       start;
  logic [NMVU*DESCW-1:0] desc;
  logic [NMVU-1:0]       done;
  logic [NMVU-1:0]       busy;
  logic [NMVU*CW-1:0]    qcount;
  logic [TOW-1:0]        timeout_cyc;
  logic [NMVU-1:0]       abort;
  logic [NMVU-1:0]       irq_mask;
  logic [NMVU-1:0]       irq_clr;
  logic [NMVU-1:0]       irq;
  logic [NMVU-1:0]       err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending jobs as queues, act = cycles since launch (0 = idle,
  // 1 = start cycle, n >= 2 = (n-1)th running cycle).
  logic [DESCW-1:0] mq [NMVU][$];
  int               act [NMVU];
  logic [DESCW-1:0] mdesc [NMVU];
  logic [NMVU-1:0]  mpend;
  logic [NMVU-1:0]  merr;

  always #5 clk = ~clk;

  mvu_job_sched #(.NMVU(NMVU), .DESCW(DESCW), .QDEPTH(QDEPTH), .TOW(TOW)) dut (
    .clk(clk), .rst_n(rst_n), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_mvu(sub_mvu), .sub_desc(sub_desc), .start(start), .desc(desc),
    .done(done), .busy(busy), .qcount(qcount), .timeout_cyc(timeout_cyc),
    .abort(abort), .irq_mask(irq_mask), .irq_clr(irq_clr), .irq(irq), .err(err)
  );

  function automatic logic [CW-1:0] qc(input int c);
    return qcount[c*CW +: CW];
  endfunction

  function automatic logic [DESCW-1:0] ds(input int c);
    return desc[c*DESCW +: DESCW];
  endfunction

  function automatic logic m_ready();
    int c;
    c = int'(sub_mvu);
    if (c >= NMVU) return 1'b0;
    return (mq[c].size() < QDEPTH) || (act[c] == 0 && mq[c].size() > 0 && !abort[c]);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NMVU; c++) begin
      mq[c].delete();
      act[c]   = 0;
      mdesc[c] = '0;
    end
    mpend = '0;
    merr  = '0;
  endtask

  task automatic m_tick();
    logic acc;
    logic sp;
    logic se;
    acc = sub_valid && m_ready();
    for (int c = 0; c < NMVU; c++) begin
      sp = 1'b0;
      se = 1'b0;
      if (abort[c]) begin
        mq[c].delete();
        act[c] = 0;
      end else begin
        if (act[c] == 0) begin
          if (mq[c].size() > 0) begin
            mdesc[c] = mq[c].pop_front();
            act[c]   = 1;
          end
        end else if (act[c] == 1) begin
          act[c] = 2;
        end else if (done[c]) begin
          sp     = 1'b1;
          act[c] = 0;
        end else if (timeout_cyc != '0 && (act[c] - 1) == int'(timeout_cyc)) begin
          sp     = 1'b1;
          se     = 1'b1;
          act[c] = 0;
        end else begin
          act[c]++;
        end
        if (acc && int'(sub_mvu) == c) mq[c].push_back(sub_desc);
      end
      mpend[c] = sp | (mpend[c] & ~irq_clr[c]);
      merr[c]  = se | (merr[c] & ~irq_clr[c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) m_tick();
    #1;
  endtask

  task automatic clear_inputs();
    sub_valid   = 1'b0;
    sub_mvu     = '0;
    sub_desc    = '0;
    done        = '0;
    abort       = '0;
    irq_mask    = '0;
    irq_clr     = '0;
    timeout_cyc = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic submit(input int c, input logic [DESCW-1:0] d);
    sub_valid = 1'b1;
    sub_mvu   = MW'(c);
    sub_desc  = d;
    step();
    sub_valid = 1'b0;
  endtask

  task automatic wait_start(input int c, input string tag);
    int n;
    n = 0;
    while (start[c] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (start[c] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s: start[%0d]=%b after 50 cycles, want 1", tag, c, start[c]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_reset();
    #2;
    vectors++;
    if (start !== '0 || busy !== '0 || irq !== '0 || err !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: start=%h busy=%h irq=%h err=%h, want all 0", start, busy, irq, err);
    end
    vectors++;
    if (qcount !== '0 || desc !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: qcount=%h desc=%h, want 0", qcount, desc);
    end
    vectors++;
    if (sub_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: sub_ready=%b, want 1", sub_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) submit(2, DESCW'(64'h200 + k));
    step();
    vectors++;
    if (busy[2] !== 1'b1 || qc(2) !== CW'(3)) begin
      miscompares++;
      $display("[TB] FAIL reset_prerun: busy[2]=%b qcount[2]=%0d, want 1 and 3", busy[2], qc(2));
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    vectors++;
    if (busy !== '0 || qcount !== '0 || start !== '0 || irq !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: busy=%h qcount=%h start=%h irq=%h, want 0", busy, qcount, start, irq);
    end
    step();
    rst_n = 1'b1;
    submit(2, 64'hA5);
    vectors++;
    if (start[2] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_lat1: start[2]=%b one edge after accept, want 0", start[2]);
    end
    step();
    vectors++;
    if (start[2] !== 1'b1 || ds(2) !== 64'hA5) begin
      miscompares++;
      $display("[TB] FAIL reset_lat2: start[2]=%b desc[2]=%h, want 1 and a5", start[2], ds(2));
    end
    step();
    vectors++;
    if (start[2] !== 1'b0 || busy[2] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_pulse: start[2]=%b busy[2]=%b, want 0 and 1", start[2], busy[2]);
    end
    done[2] = 1'b1;
    step();
    done[2] = 1'b0;
    irq_clr = '1;
    step();
    irq_clr = '0;
  endtask

  task automatic test_queue_fill();
    apply_reset();
    for (int k = 0; k < 5; k++) submit(0, DESCW'(64'h100 + k));
    vectors++;
    if (qc(0) !== CW'(4) || busy[0] !== 1'b1 || ds(0) !== 64'h100) begin
      miscompares++;
      $display("[TB] FAIL fill_state: qcount[0]=%0d busy[0]=%b desc[0]=%h, want 4 1 100", qc(0), busy[0], ds(0));
    end
    sub_mvu = 3'd0;
    #1;
    vectors++;
    if (sub_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_ready0: sub_ready=%b, want 0", sub_ready);
    end
    sub_mvu = 3'd1;
    #1;
    vectors++;
    if (sub_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_ready1: sub_ready=%b, want 1", sub_ready);
    end
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    vectors++;
    if (start[0] !== 1'b0 || busy[0] !== 1'b0 || irq[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_done: start=%b busy=%b irq=%b, want 0 0 1", start[0], busy[0], irq[0]);
    end
    sub_valid = 1'b1;
    sub_mvu   = 3'd0;
    sub_desc  = 64'h105;
    #1;
    vectors++;
    if (sub_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop_ready: sub_ready=%b, want 1", sub_ready);
    end
    step();
    sub_valid = 1'b0;
    vectors++;
    if (qc(0) !== CW'(4) || start[0] !== 1'b1 || ds(0) !== 64'h101) begin
      miscompares++;
      $display("[TB] FAIL full_pushpop: qcount=%0d start=%b desc=%h, want 4 1 101", qc(0), start[0], ds(0));
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      done[0] = 1'b1;
      step();
      done[0] = 1'b0;
      step();
      vectors++;
      if (start[0] !== 1'b1 || ds(0) !== DESCW'(64'h100 + k)) begin
        miscompares++;
        $display("[TB] FAIL fifo_order%0d: start=%b desc=%h, want 1 %h", k, start[0], ds(0), 64'h100 + k);
      end
    end
    vectors++;
    if (qc(0) !== CW'(0)) begin
      miscompares++;
      $display("[TB] FAIL fifo_drain: qcount[0]=%0d, want 0", qc(0));
    end
  endtask

  task automatic test_watchdog();
    int n;
    apply_reset();
    timeout_cyc = 16'd10;
    submit(3, 64'h300);
    wait_start(3, "wd_start");
    n = 0;
    step();
    while (busy[3] === 1'b1 && n < 40) begin
      n++;
      step();
    end
    vectors++;
    if (n != 10 || err[3] !== 1'b1 || irq[3] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wd_expire: run=%0d err=%b irq=%b, want 10 1 1", n, err[3], irq[3]);
    end
    irq_clr[3] = 1'b1;
    step();
    irq_clr[3] = 1'b0;
    vectors++;
    if (err[3] !== 1'b0 || irq[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wd_clear: err=%b irq=%b, want 0 0", err[3], irq[3]);
    end
    timeout_cyc = '0;
    submit(3, 64'h301);
    wait_start(3, "wd_off_start");
    repeat (1000) step();
    vectors++;
    if (busy[3] !== 1'b1 || err[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wd_disabled: busy=%b err=%b, want 1 0", busy[3], err[3]);
    end
    done[3] = 1'b1;
    step();
    done[3] = 1'b0;
    vectors++;
    if (irq[3] !== 1'b1 || err[3] !== 1'b0 || busy[3] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wd_late_done: irq=%b err=%b busy=%b, want 1 0 0", irq[3], err[3], busy[3]);
    end
  endtask

  task automatic test_irq();
    apply_reset();
    irq_mask = 8'h02;
    submit(1, 64'h10);
    wait_start(1, "irq_start");
    step();
    done[1] = 1'b1;
    step();
    done[1] = 1'b0;
    vectors++;
    if (irq[1] !== 1'b0 || busy[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_masked: irq=%b busy=%b, want 0 0", irq[1], busy[1]);
    end
    irq_mask = '0;
    #1;
    vectors++;
    if (irq[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL irq_unmask: irq=%b, want 1", irq[1]);
    end
    submit(1, 64'h11);
    wait_start(1, "irq_start2");
    step();
    done[1]    = 1'b1;
    irq_clr[1] = 1'b1;
    step();
    done[1]    = 1'b0;
    irq_clr[1] = 1'b0;
    vectors++;
    if (irq[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL irq_set_wins: irq=%b, want 1", irq[1]);
    end
    irq_clr[1] = 1'b1;
    step();
    irq_clr[1] = 1'b0;
    vectors++;
    if (irq[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_clear: irq=%b, want 0", irq[1]);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    for (int k = 0; k < 3; k++) submit(4, DESCW'(64'h400 + k));
    vectors++;
    if (busy[4] !== 1'b1 || qc(4) !== CW'(2)) begin
      miscompares++;
      $display("[TB] FAIL abort_setup: busy=%b qcount=%0d, want 1 2", busy[4], qc(4));
    end
    abort[4]  = 1'b1;
    done[4]   = 1'b1;
    sub_valid = 1'b1;
    sub_mvu   = 3'd4;
    sub_desc  = 64'h4FF;
    #1;
    vectors++;
    if (sub_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_handshake: sub_ready=%b, want 1", sub_ready);
    end
    step();
    done[4]   = 1'b0;
    sub_valid = 1'b0;
    vectors++;
    if (busy[4] !== 1'b0 || qc(4) !== CW'(0) || irq[4] !== 1'b0 || err[4] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_flush: busy=%b qcount=%0d irq=%b err=%b, want 0 0 0 0", busy[4], qc(4), irq[4], err[4]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (start[4] !== 1'b0 || qc(4) !== CW'(0)) begin
        miscompares++;
        $display("[TB] FAIL abort_hold%0d: start=%b qcount=%0d, want 0 0", k, start[4], qc(4));
      end
    end
    abort[4] = 1'b0;
    step();
    step();
    vectors++;
    if (busy[4] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_release: busy=%b, want 0", busy[4]);
    end
  endtask

  task automatic test_random();
    logic [NMVU-1:0]       es;
    logic [NMVU-1:0]       eb;
    logic [NMVU*CW-1:0]    eq;
    logic [NMVU*DESCW-1:0] ed;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      sub_valid = ($urandom_range(0, 1) == 1);
      sub_mvu   = MW'($urandom_range(0, NMVU - 1));
      sub_desc  = {$urandom, $urandom};
      for (int c = 0; c < NMVU; c++) begin
        done[c]    = ($urandom_range(0, 7) == 0);
        abort[c]   = ($urandom_range(0, 40) == 0);
        irq_clr[c] = ($urandom_range(0, 15) == 0);
      end
      if (cyc % 64 == 0) begin
        irq_mask    = NMVU'($urandom);
        timeout_cyc = TOW'($urandom_range(0, 12));
      end
      #1;
      vectors++;
      if (sub_ready !== m_ready()) begin
        miscompares++;
        $display("[TB] FAIL rnd_ready cyc %0d: sub_ready=%b, want %b", cyc, sub_ready, m_ready());
      end
      step();
      for (int c = 0; c < NMVU; c++) begin
        es[c]                = (act[c] == 1);
        eb[c]                = (act[c] != 0);
        eq[c*CW +: CW]       = CW'(mq[c].size());
        ed[c*DESCW +: DESCW] = mdesc[c];
      end
      vectors++;
      if ({start, busy, irq, err} !== {es, eb, mpend & ~irq_mask, merr}) begin
        miscompares++;
        $display("[TB] FAIL rnd_ctl cyc %0d: start=%h busy=%h irq=%h err=%h, want %h %h %h %h",
                 cyc, start, busy, irq, err, es, eb, mpend & ~irq_mask, merr);
      end
      vectors++;
      if (qcount !== eq) begin
        miscompares++;
        $display("[TB] FAIL rnd_qcount cyc %0d: qcount=%h, want %h", cyc, qcount, eq);
      end
      vectors++;
      if (desc !== ed) begin
        miscompares++;
        $display("[TB] FAIL rnd_desc cyc %0d: desc=%h, want %h", cyc, desc, ed);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    test_reset();
    test_queue_fill();
    test_watchdog();
    test_irq();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
